// File: rtl/pipeline_hazard_scoreboard_if.sv
// Decode-side handshake bundle for pipeline_hazard_scoreboard.
// With HAZARD_PERF_CNT_EN defined the bundle also carries the stall/forward performance counters.
interface pipeline_hazard_scoreboard_if #(
    parameter int REGISTER_SIZE  = 5,
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 3,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
);
    logic                             issue_valid;
    logic                             issue_we;
    logic [REGISTER_SIZE-1:0]         issue_rd;
    logic                             issue_is_load;
    logic [NUM_SRC-1:0]               src_used;
    logic [NUM_SRC*REGISTER_SIZE-1:0] src_addr;
    logic                             flush;
    logic                             ext_hold;
    logic [NUM_SRC*SEL_W-1:0]         fwd_sel;
    logic                             stall;
    logic                             hold_all;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]                      perf_stall_cnt;
    logic [31:0]                      perf_fwd_cnt;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_is_load, src_used, src_addr, flush, ext_hold,
        input  fwd_sel, stall, hold_all, perf_stall_cnt, perf_fwd_cnt
    );
    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_is_load, src_used, src_addr, flush, ext_hold,
        output fwd_sel, stall, hold_all, perf_stall_cnt, perf_fwd_cnt
    );
`else
    modport master (
        output issue_valid, issue_we, issue_rd, issue_is_load, src_used, src_addr, flush, ext_hold,
        input  fwd_sel, stall, hold_all
    );
    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_is_load, src_used, src_addr, flush, ext_hold,
        output fwd_sel, stall, hold_all
    );
`endif
endinterface

// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight writes from EXECUTE onward.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue, forwarding selects valid
// LU_STALL | decode operand needs a load result that is not yet available
// EXT_HOLD | ext_hold asserted: every stage and the scoreboard are frozen
module pipeline_hazard_scoreboard #(
    parameter int REGISTER_SIZE  = 5,
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 3,
    parameter int LOAD_LATENCY   = 1,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input logic                     clk,
    input logic                     rst,
    pipeline_hazard_scoreboard_if.slave sb
);
    typedef struct packed {
        logic                     valid;
        logic                     we;
        logic [REGISTER_SIZE-1:0] rd;
        logic                     is_load;
    } slot_t;

    typedef enum logic [1:0] {RUN, LU_STALL, EXT_HOLD} state_t;

    slot_t                    slot_q [NUM_FWD_STAGES];
    state_t                   state_q, state_d;
    logic [NUM_SRC-1:0]       op_lu;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
    logic                     lu_hazard;
    logic                     stall;
    logic                     hold_all;
    logic                     accept;

    // Scan oldest to youngest so the youngest matching slot overrides.
    always_comb begin
        op_lu     = '0;
        fwd_sel_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                if (sb.src_used[i] && (sb.src_addr[i*REGISTER_SIZE +: REGISTER_SIZE] != '0) &&
                    slot_q[k].valid && slot_q[k].we &&
                    (slot_q[k].rd == sb.src_addr[i*REGISTER_SIZE +: REGISTER_SIZE])) begin
                    op_lu[i]                       = slot_q[k].is_load && (k < LOAD_LATENCY);
                    fwd_sel_d[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
                end
            end
            // A load still too young has no forwardable result yet.
            if (op_lu[i] || rst) begin
                fwd_sel_d[i*SEL_W +: SEL_W] = '0;
            end
        end
    end

    assign lu_hazard = sb.issue_valid && !sb.flush && (|op_lu);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (lu_hazard)  state_d = LU_STALL;
            LU_STALL: if (!lu_hazard) state_d = RUN;
            EXT_HOLD: state_d = lu_hazard ? LU_STALL : RUN;
            default:  state_d = RUN;
        endcase
        if (sb.ext_hold) state_d = EXT_HOLD;
        if (rst)         state_d = RUN;
    end

    assign stall    = (state_d != RUN);
    assign hold_all = (state_d == EXT_HOLD);
    assign accept   = sb.issue_valid && !sb.flush && !stall;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_FWD_STAGES; k++) slot_q[k] <= '0;
        end else if (!hold_all) begin
            for (int k = NUM_FWD_STAGES - 1; k > 0; k--) slot_q[k] <= slot_q[k-1];
            slot_q[0] <= accept ? slot_t'{valid: 1'b1, we: sb.issue_we, rd: sb.issue_rd,
                                          is_load: sb.issue_is_load}
                                : slot_t'('0);
        end
    end

    assign sb.fwd_sel  = fwd_sel_d;
    assign sb.stall    = stall;
    assign sb.hold_all = hold_all;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_fwd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            if (stall && !sb.ext_hold)                 perf_stall_q <= perf_stall_q + 32'd1;
            if ((|fwd_sel_d) && !stall && !hold_all)   perf_fwd_q   <= perf_fwd_q + 32'd1;
        end
    end

    assign sb.perf_stall_cnt = perf_stall_q;
    assign sb.perf_fwd_cnt   = perf_fwd_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for pipeline_hazard_scoreboard: directed scenarios then random traffic against a queue model.
module tb_pipeline_hazard_scoreboard;
    localparam int RS = 5;
    localparam int NS = 2;
    localparam int NF = 3;
    localparam int LL = 1;
    localparam int SW = $clog2(NF + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_scoreboard_if #(.REGISTER_SIZE(RS), .NUM_SRC(NS), .NUM_FWD_STAGES(NF), .SEL_W(SW)) sb();

    pipeline_hazard_scoreboard #(
        .REGISTER_SIZE(RS), .NUM_SRC(NS), .NUM_FWD_STAGES(NF), .LOAD_LATENCY(LL), .SEL_W(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb)
    );

    typedef struct {
        bit       valid;
        bit       we;
        bit [4:0] rd;
        bit       ld;
    } ent_t;

    ent_t pipe[$];                 // index 0 = instruction currently in EXECUTE
    bit [NS*SW-1:0] m_sel;
    bit             m_stall;
    bit             m_hold;
    int unsigned    m_stall_cnt;
    int unsigned    m_fwd_cnt;
    int             total = 0;
    int             bad   = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(bit v, bit we, bit [4:0] rd, bit ld, bit [1:0] used,
                         bit [4:0] a0, bit [4:0] a1, bit fl, bit eh);
        sb.issue_valid   = v;
        sb.issue_we      = we;
        sb.issue_rd      = rd;
        sb.issue_is_load = ld;
        sb.src_used      = used;
        sb.src_addr      = {a1, a0};
        sb.flush         = fl;
        sb.ext_hold      = eh;
    endtask

    function automatic logic [SW-1:0] sel_of(int i);
        return sb.fwd_sel[i*SW +: SW];
    endfunction

    // Find the youngest in-flight writer of each operand and decide forward/stall from its age.
    task automatic model_eval();
        bit haz = 1'b0;
        m_sel   = '0;
        m_stall = 1'b0;
        m_hold  = 1'b0;
        if (rst) return;
        for (int i = 0; i < NS; i++) begin
            bit [4:0] a = sb.src_addr[i*RS +: RS];
            if (!sb.src_used[i] || a == 5'd0) continue;
            for (int k = 0; k < pipe.size(); k++) begin
                if (pipe[k].valid && pipe[k].we && pipe[k].rd == a) begin
                    if (pipe[k].ld && k < LL) haz = 1'b1;
                    else m_sel[i*SW +: SW] = SW'(k + 1);
                    break;
                end
            end
        end
        if (!(sb.issue_valid && !sb.flush)) haz = 1'b0;
        if (sb.ext_hold) begin
            m_stall = 1'b1;
            m_hold  = 1'b1;
        end else begin
            m_stall = haz;
        end
    endtask

    task automatic model_update();
        ent_t e;
        if (rst) begin
            pipe.delete();
            for (int k = 0; k < NF; k++) pipe.push_back('{default: 0});
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
            return;
        end
        if (m_stall && !sb.ext_hold) m_stall_cnt++;
        if (m_sel != '0 && !m_stall && !m_hold) m_fwd_cnt++;
        if (sb.ext_hold) return;
        e = '{default: 0};
        if (sb.issue_valid && !sb.flush && !m_stall)
            e = '{valid: 1'b1, we: sb.issue_we, rd: sb.issue_rd, ld: sb.issue_is_load};
        pipe.push_front(e);
        void'(pipe.pop_back());
    endtask

    task automatic step(string tag);
        #1;
        model_eval();
        chk({tag, "/stall"},    32'(sb.stall),    32'(m_stall));
        chk({tag, "/hold_all"}, 32'(sb.hold_all), 32'(m_hold));
        chk({tag, "/fwd_sel"},  32'(sb.fwd_sel),  32'(m_sel));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "/perf_stall"}, sb.perf_stall_cnt, m_stall_cnt);
        chk({tag, "/perf_fwd"},   sb.perf_fwd_cnt,   m_fwd_cnt);
`endif
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hold_left = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        step("reset");
        step("reset2");
        rst = 1'b0;

        // ALU -> ALU forward from EXECUTE
        drive(1, 1, 5, 0, 2'b00, 0, 0, 0, 0);  step("alu_issue");
        drive(0, 0, 0, 0, 2'b01, 5, 0, 0, 0);
        #1 chk("alu_fwd0", 32'(sel_of(0)), 32'd1);
        step("alu_use");

        // load-use: one stall cycle, then forward from slot 1
        drive(1, 1, 6, 1, 2'b00, 0, 0, 0, 0);  step("lw_issue");
        drive(1, 1, 9, 0, 2'b10, 0, 6, 0, 0);
        #1 chk("lu_stall", 32'(sb.stall), 32'd1);
        step("lu_stall");
        #1 chk("lu_after_stall", 32'(sb.stall), 32'd0);
        chk("lu_fwd1", 32'(sel_of(1)), 32'd2);
        step("lu_resume");

        // youngest writer wins
        drive(1, 1, 7, 0, 2'b00, 0, 0, 0, 0);  step("y_a");
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);  step("y_b");
        drive(1, 1, 7, 0, 2'b00, 0, 0, 0, 0);  step("y_c");
        drive(0, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        #1 chk("youngest_fwd0", 32'(sel_of(0)), 32'd1);
        step("y_use");

        // x0 never forwarded
        drive(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);  step("x0_issue");
        drive(0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
        #1 chk("x0_fwd0", 32'(sel_of(0)), 32'd0);
        step("x0_use");

        // flush beats load-use, bubble enters slot 0
        drive(1, 1, 8, 1, 2'b00, 0, 0, 0, 0);  step("fl_lw");
        drive(1, 1, 10, 0, 2'b01, 8, 0, 1, 0);
        #1 chk("flush_stall", 32'(sb.stall), 32'd0);
        step("fl_hazard");
        drive(0, 0, 0, 0, 2'b11, 10, 8, 0, 0);
        #1 chk("flush_bubble", 32'(sel_of(0)), 32'd0);
        chk("flush_lw_slot1", 32'(sel_of(1)), 32'd2);
        step("fl_after");

        // external hold for 3 cycles freezes the scoreboard
        drive(1, 1, 11, 0, 2'b00, 0, 0, 0, 0); step("eh_pre");
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 12, 0, 2'b01, 11, 0, 0, 1);
            #1 chk("eh_hold_all", 32'(sb.hold_all), 32'd1);
            chk("eh_fwd0", 32'(sel_of(0)), 32'd1);
            step("eh_hold");
        end
        drive(1, 1, 12, 0, 2'b01, 11, 0, 0, 0); step("eh_release");
        drive(0, 0, 0, 0, 2'b11, 12, 11, 0, 0);
        #1 chk("eh_order0", 32'(sel_of(0)), 32'd1);
        chk("eh_order1", 32'(sel_of(1)), 32'd2);
        step("eh_order");

        // reset during a load-use stall
        drive(1, 1, 13, 1, 2'b00, 0, 0, 0, 0); step("rs_lw");
        drive(1, 0, 0, 0, 2'b01, 13, 0, 0, 0); step("rs_stall");
        rst = 1'b1;                            step("rs_rst");
        rst = 1'b0;
        #1 chk("rs_stall_clear", 32'(sb.stall), 32'd0);
        chk("rs_fwd_clear", 32'(sb.fwd_sel), 32'd0);
        step("rs_after");

        // random traffic on a small register set to provoke many hazards
        for (int n = 0; n < 3000; n++) begin
            bit eh;
            if (hold_left > 0) hold_left--;
            else if ($urandom_range(0, 99) < 6) hold_left = $urandom_range(1, 4);
            eh = (hold_left > 0);
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 35, 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 10, eh);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
